// File: rtl/watch_pkg.sv
// Shared encodings for the watch mode/sequence controller and its helpers.
package watch_pkg;

  typedef enum logic {
    ST_CLOCK = 1'b0,
    ST_SETUP = 1'b1
  } state_t;

  localparam logic [1:0] POS_SEC  = 2'd0;
  localparam logic [1:0] POS_MIN  = 2'd1;
  localparam logic [1:0] POS_HOUR = 2'd2;

  localparam logic [5:0] DP_SEP = 6'b010100;

  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/watch_tick_gen.sv
// Free-running one-second tick generator with half-period flag and
// synchronous restart so a new second can start at a known phase.
module watch_tick_gen
  import watch_pkg::*;
#(
  parameter int TICK_NUM = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick,
  output logic half
);

  localparam int TW = cnt_width(TICK_NUM);

  logic [TW-1:0] tick_cnt;

  assign tick = (tick_cnt == TW'(TICK_NUM - 1));
  assign half = (tick_cnt < TW'(TICK_NUM / 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (restart || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/watch_ctrl.sv
// CLOCK/SETUP controller: field increment/clear pulses with carry chaining,
// setup-mode field selection with blink and idle timeout, display masks.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CLOCK | time runs; ticks drive inc pulses with carry chain
// ST_SETUP | ticks only age the idle timer; buttons select/adjust field
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int TICK_NUM    = 50000000,
  parameter int BLINK_NUM   = 25000000,
  parameter int TIMEOUT_SEC = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_btn_mode,
  input  logic       i_btn_pos,
  input  logic       i_btn_inc,
  input  logic       i_sec_max,
  input  logic       i_min_max,
  output logic       o_mode,
  output logic [1:0] o_pos,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic       o_sec_clr,
  output logic [5:0] o_digit_enb,
  output logic [5:0] o_six_dp
);

  localparam int BW = cnt_width(BLINK_NUM);
  localparam int IW = cnt_width(TIMEOUT_SEC);

  state_t        state, state_nxt;
  logic [1:0]    pos_nxt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_phase, blink_phase_nxt;
  logic [IW-1:0] idle_cnt, idle_cnt_nxt;
  logic          sec_inc_nxt, min_inc_nxt, hour_inc_nxt, sec_clr_nxt;
  logic [5:0]    digit_enb_nxt, six_dp_nxt;
  logic          restart, tick, half;
  logic          any_btn;

  watch_tick_gen #(
    .TICK_NUM (TICK_NUM)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick),
    .half    (half)
  );

  assign any_btn = i_btn_mode | i_btn_pos | i_btn_inc;

  always_comb begin
    state_nxt       = state;
    pos_nxt         = o_pos;
    blink_cnt_nxt   = blink_cnt;
    blink_phase_nxt = blink_phase;
    idle_cnt_nxt    = idle_cnt;
    sec_inc_nxt     = 1'b0;
    min_inc_nxt     = 1'b0;
    hour_inc_nxt    = 1'b0;
    sec_clr_nxt     = 1'b0;
    restart         = 1'b0;

    case (state)
      ST_CLOCK: begin
        if (i_btn_mode) begin
          state_nxt = ST_SETUP;
          pos_nxt   = POS_SEC;
        end else if (tick) begin
          sec_inc_nxt  = 1'b1;
          min_inc_nxt  = i_sec_max;
          hour_inc_nxt = i_sec_max & i_min_max;
        end
      end
      ST_SETUP: begin
        if (any_btn) begin
          idle_cnt_nxt    = '0;
          blink_cnt_nxt   = '0;
          blink_phase_nxt = 1'b1;
          if (i_btn_mode) begin
            state_nxt = ST_CLOCK;
            restart   = 1'b1;
          end else if (i_btn_pos) begin
            pos_nxt = (o_pos == POS_HOUR) ? POS_SEC : o_pos + 2'd1;
          end else begin
            case (o_pos)
              POS_SEC:  sec_clr_nxt  = 1'b1;
              POS_MIN:  min_inc_nxt  = 1'b1;
              POS_HOUR: hour_inc_nxt = 1'b1;
              default:  ;
            endcase
          end
        end else begin
          if (blink_cnt == BW'(BLINK_NUM - 1)) begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = ~blink_phase;
          end else begin
            blink_cnt_nxt = blink_cnt + BW'(1);
          end
          if (tick) begin
            if (idle_cnt == IW'(TIMEOUT_SEC - 1)) begin
              state_nxt    = ST_CLOCK;
              restart      = 1'b1;
              idle_cnt_nxt = '0;
            end else begin
              idle_cnt_nxt = idle_cnt + IW'(1);
            end
          end
        end
      end
      default: state_nxt = ST_CLOCK;
    endcase

    // Fresh SETUP entry must start visible; CLOCK keeps the blink parked.
    if (state_nxt == ST_CLOCK || state == ST_CLOCK) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = 1'b1;
      idle_cnt_nxt    = '0;
    end

    digit_enb_nxt = 6'b111111;
    if (state_nxt == ST_SETUP) begin
      case (pos_nxt)
        POS_SEC:  digit_enb_nxt[1:0] = {2{blink_phase_nxt}};
        POS_MIN:  digit_enb_nxt[3:2] = {2{blink_phase_nxt}};
        POS_HOUR: digit_enb_nxt[5:4] = {2{blink_phase_nxt}};
        default:  ;
      endcase
    end

    six_dp_nxt = (state_nxt == ST_CLOCK && half) ? DP_SEP : 6'b000000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_CLOCK;
      o_pos       <= POS_SEC;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      idle_cnt    <= '0;
      o_sec_inc   <= 1'b0;
      o_min_inc   <= 1'b0;
      o_hour_inc  <= 1'b0;
      o_sec_clr   <= 1'b0;
      o_digit_enb <= 6'b111111;
      o_six_dp    <= 6'b000000;
    end else begin
      state       <= state_nxt;
      o_pos       <= pos_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      idle_cnt    <= idle_cnt_nxt;
      o_sec_inc   <= sec_inc_nxt;
      o_min_inc   <= min_inc_nxt;
      o_hour_inc  <= hour_inc_nxt;
      o_sec_clr   <= sec_clr_nxt;
      o_digit_enb <= digit_enb_nxt;
      o_six_dp    <= six_dp_nxt;
    end
  end

  assign o_mode = (state == ST_SETUP);

endmodule

// File: tb/tb_watch_ctrl.sv
// Scoreboard bench for watch_ctrl: a cycle model pushes expected outputs
// when inputs are driven; they are popped and compared after each edge.
module tb_watch_ctrl;

  localparam int TN = 10;
  localparam int BN = 4;
  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_btn_mode = 1'b0, i_btn_pos = 1'b0, i_btn_inc = 1'b0;
  logic       i_sec_max = 1'b0, i_min_max = 1'b0;
  logic       o_mode;
  logic [1:0] o_pos;
  logic       o_sec_inc, o_min_inc, o_hour_inc, o_sec_clr;
  logic [5:0] o_digit_enb, o_six_dp;

  watch_ctrl #(.TICK_NUM(TN), .BLINK_NUM(BN), .TIMEOUT_SEC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_btn_mode  (i_btn_mode),
    .i_btn_pos   (i_btn_pos),
    .i_btn_inc   (i_btn_inc),
    .i_sec_max   (i_sec_max),
    .i_min_max   (i_min_max),
    .o_mode      (o_mode),
    .o_pos       (o_pos),
    .o_sec_inc   (o_sec_inc),
    .o_min_inc   (o_min_inc),
    .o_hour_inc  (o_hour_inc),
    .o_sec_clr   (o_sec_clr),
    .o_digit_enb (o_digit_enb),
    .o_six_dp    (o_six_dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [1:0] pos;
    logic [3:0] pulse;   // {sec_clr, hour_inc, min_inc, sec_inc}
    logic [5:0] enb;
    logic [5:0] dp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int m_setup, m_pos, m_tick, m_blink, m_phase, m_idle;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_setup = 0; m_pos = 0; m_tick = 0; m_blink = 0; m_phase = 1; m_idle = 0;
  endtask

  task automatic model_step(input logic bm, bp, bi, sm, mm);
    exp_t e;
    bit   tk, hf, rs;
    int   nsetup;
    tk = (m_tick == TN - 1);
    hf = (m_tick < TN / 2);
    rs = 1'b0;
    nsetup = m_setup;
    e.pulse = 4'b0000;
    if (m_setup == 0) begin
      if (bm) begin
        nsetup = 1; m_pos = 0; m_blink = 0; m_phase = 1; m_idle = 0;
      end else if (tk) begin
        e.pulse = {1'b0, sm & mm, sm, 1'b1};
      end
    end else if (bm || bp || bi) begin
      m_idle = 0; m_blink = 0; m_phase = 1;
      if (bm) begin
        nsetup = 0; rs = 1'b1;
      end else if (bp) begin
        m_pos = (m_pos + 1) % 3;
      end else begin
        case (m_pos)
          0: e.pulse = 4'b1000;
          1: e.pulse = 4'b0010;
          default: e.pulse = 4'b0100;
        endcase
      end
    end else begin
      m_blink++;
      if (m_blink == BN) begin
        m_blink = 0; m_phase = 1 - m_phase;
      end
      if (tk) begin
        m_idle++;
        if (m_idle == TO) begin
          nsetup = 0; rs = 1'b1; m_idle = 0;
        end
      end
    end
    if (nsetup == 0) begin
      m_phase = 1; m_blink = 0;
    end
    m_setup = nsetup;
    m_tick = (rs || tk) ? 0 : m_tick + 1;
    e.mode = (m_setup != 0);
    e.pos  = 2'(m_pos);
    e.enb  = 6'b111111;
    if (m_setup != 0 && m_phase == 0) e.enb[2*m_pos +: 2] = 2'b00;
    e.dp   = (m_setup == 0 && hf) ? 6'b010100 : 6'b000000;
    sb.push_back(e);
  endtask

  task automatic cycle(input logic bm, bp, bi, sm, mm);
    exp_t e;
    i_btn_mode = bm; i_btn_pos = bp; i_btn_inc = bi;
    i_sec_max = sm; i_min_max = mm;
    model_step(bm, bp, bi, sm, mm);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_val("mode", 32'(o_mode), 32'(e.mode));
    chk_val("pos", 32'(o_pos), 32'(e.pos));
    chk_val("pulses", 32'({o_sec_clr, o_hour_inc, o_min_inc, o_sec_inc}), 32'(e.pulse));
    chk_val("digit_enb", 32'(o_digit_enb), 32'(e.enb));
    chk_val("six_dp", 32'(o_six_dp), 32'(e.dp));
    i_btn_mode = 1'b0; i_btn_pos = 1'b0; i_btn_inc = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_val({tag, "_mode"}, 32'(o_mode), 32'd0);
    chk_val({tag, "_pos"}, 32'(o_pos), 32'd0);
    chk_val({tag, "_pulses"}, 32'({o_sec_clr, o_hour_inc, o_min_inc, o_sec_inc}), 32'd0);
    chk_val({tag, "_enb"}, 32'(o_digit_enb), 32'h3f);
    chk_val({tag, "_dp"}, 32'(o_six_dp), 32'h00);
  endtask

  // cycles until the next o_sec_inc, bounded
  task automatic cycles_to_sec_inc(output int n);
    n = 0;
    do begin
      cycle(0, 0, 0, 0, 0);
      n++;
    end while (!o_sec_inc && n < 3 * TN);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // free run: two ticks in 25 cycles, no carries
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (o_sec_inc) cnt++;
    end
    chk_val("sec_inc_count", 32'(cnt), 32'd2);

    // full carry chain on the third tick
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 1, 1);
      if (o_sec_inc && o_min_inc && o_hour_inc) cnt++;
    end
    chk_val("carry_all_count", 32'(cnt), 32'd1);

    // setup: select MIN and bump it, then watch the blink
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk_val("setup_min_inc", 32'(o_min_inc), 32'd1);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 0);

    // mode + inc together: back to CLOCK, inc dropped, full first second
    cycle(1, 0, 1, 0, 0);
    chk_val("mode_inc_pulses", 32'({o_sec_clr, o_hour_inc, o_min_inc, o_sec_inc}), 32'd0);
    cycles_to_sec_inc(n);
    chk_val("sec_inc_after_exit", 32'(n), 32'(TN));

    // idle timeout after TO ticks
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < TO * TN + 5; i++) cycle(0, 0, 0, 0, 0);
    chk_val("timeout_mode", 32'(o_mode), 32'd0);
    chk_val("timeout_enb", 32'(o_digit_enb), 32'h3f);

    // async reset mid-SETUP with HOUR selected
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    chk_val("pre_reset_pos", 32'(o_pos), 32'd2);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk_reset_vals("held_reset");
    rst_n = 1'b1;
    cycles_to_sec_inc(n);
    chk_val("sec_inc_after_reset", 32'(n), 32'(TN));

    // random mix of buttons and carry inputs
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    chk_val("queue_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
